// File: rtl/ddr_cmd_sched.sv
// rtl/ddr_cmd_sched.sv - DDR3 command scheduler: rd/wr arbitration, open-row tracking,
// PRE/ACT insertion with tRP/tRCD spacing, periodic PREA+REF refresh.
module ddr_cmd_sched #(
  parameter int BA_W   = 3,
  parameter int ROW_W  = 16,
  parameter int COL_W  = 10,
  parameter int T_RP   = 6,
  parameter int T_RCD  = 6,
  parameter int T_RFC  = 110,
  parameter int T_REFI = 3120
) (
  input  logic             sysclk,
  input  logic             sysrst,
  input  logic             init_done,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [BA_W-1:0]  rd_ba,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [BA_W-1:0]  wr_ba,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_addr,
  output logic [3:0]       ref_owed
);

  localparam int NB   = 1 << BA_W;
  localparam int TMAX = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                       : ((T_RP > T_RCD) ? T_RP : T_RCD);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RFW  = $clog2(T_REFI);

  localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                         OP_PRE = 3'd4, OP_PREA = 3'd5, OP_REF = 3'd6;
  localparam logic [ROW_W-1:0] A10 = ROW_W'(1) << 10;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_PRE, S_TRP, S_ACT, S_TRCD, S_RW, S_PREA, S_TRPA, S_REF, S_TRFC
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             ptr_q, ptr_d;
  logic             g_wr_q, g_wr_d;
  logic [BA_W-1:0]  g_ba_q, g_ba_d;
  logic [ROW_W-1:0] g_row_q, g_row_d;
  logic [COL_W-1:0] g_col_q, g_col_d;
  logic [NB-1:0]    open_q, open_d;
  logic [ROW_W-1:0] row_q [NB];
  logic [ROW_W-1:0] row_d [NB];
  logic [RFW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [3:0]       ref_owed_q, ref_owed_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       cmd_op_q, cmd_op_d;
  logic [BA_W-1:0]  cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0] cmd_addr_q, cmd_addr_d;
  logic             hs, tick, ref_hs, pick_wr;

  assign hs     = cmd_valid_q && cmd_ready;
  assign ref_hs = (state_q == S_REF) && hs;
  assign tick   = init_done && (ref_cnt_q == RFW'(T_REFI - 1));

  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      ptr_q       <= 1'b0;
      g_wr_q      <= 1'b0;
      g_ba_q      <= '0;
      g_row_q     <= '0;
      g_col_q     <= '0;
      open_q      <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
      ref_cnt_q   <= '0;
      ref_owed_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_NOP;
      cmd_ba_q    <= '0;
      cmd_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ptr_q       <= ptr_d;
      g_wr_q      <= g_wr_d;
      g_ba_q      <= g_ba_d;
      g_row_q     <= g_row_d;
      g_col_q     <= g_col_d;
      open_q      <= open_d;
      for (int i = 0; i < NB; i++) row_q[i] <= row_d[i];
      ref_cnt_q   <= ref_cnt_d;
      ref_owed_q  <= ref_owed_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_addr_q  <= cmd_addr_d;
    end
  end

  always_comb begin
    ref_cnt_d  = init_done ? (tick ? '0 : ref_cnt_q + RFW'(1)) : ref_cnt_q;
    ref_owed_d = ref_owed_q;
    if (tick && !ref_hs && ref_owed_q != 4'd8) ref_owed_d = ref_owed_q + 4'd1;
    else if (ref_hs && !tick)                  ref_owed_d = ref_owed_q - 4'd1;
  end

  // Wait timers load T-2 so the following command's cmd_valid lands exactly T after the handshake.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ptr_d   = ptr_q;
    g_wr_d  = g_wr_q;
    g_ba_d  = g_ba_q;
    g_row_d = g_row_q;
    g_col_d = g_col_q;
    open_d  = open_q;
    row_d   = row_q;
    pick_wr = 1'b0;
    case (state_q)
      S_IDLE: if (init_done) state_d = S_ARB;
      S_ARB: begin
        if (!init_done) begin
          state_d = S_IDLE;
        end else if (ref_owed_q != 4'd0) begin
          state_d = (|open_q) ? S_PREA : S_REF;
        end else if (rd_valid || wr_valid) begin
          pick_wr = wr_valid && (!rd_valid || ptr_q);
          if (rd_valid && wr_valid) ptr_d = !ptr_q;
          g_wr_d  = pick_wr;
          g_ba_d  = pick_wr ? wr_ba  : rd_ba;
          g_row_d = pick_wr ? wr_row : rd_row;
          g_col_d = pick_wr ? wr_col : rd_col;
          if (!open_q[g_ba_d])                state_d = S_ACT;
          else if (row_q[g_ba_d] == g_row_d)  state_d = S_RW;
          else                                state_d = S_PRE;
        end
      end
      S_PRE: if (hs) begin
        open_d[g_ba_q] = 1'b0;
        tmr_d   = TW'(T_RP - 2);
        state_d = S_TRP;
      end
      S_TRP: if (tmr_q == '0) state_d = S_ACT; else tmr_d = tmr_q - TW'(1);
      S_ACT: if (hs) begin
        open_d[g_ba_q] = 1'b1;
        row_d[g_ba_q]  = g_row_q;
        tmr_d   = TW'(T_RCD - 2);
        state_d = S_TRCD;
      end
      S_TRCD: if (tmr_q == '0) state_d = S_RW; else tmr_d = tmr_q - TW'(1);
      S_RW:   if (hs) state_d = S_ARB;
      S_PREA: if (hs) begin
        open_d  = '0;
        tmr_d   = TW'(T_RP - 2);
        state_d = S_TRPA;
      end
      S_TRPA: if (tmr_q == '0) state_d = S_REF; else tmr_d = tmr_q - TW'(1);
      S_REF: if (hs) begin
        tmr_d   = TW'(T_RFC - 2);
        state_d = S_TRFC;
      end
      S_TRFC: if (tmr_q == '0) state_d = S_ARB; else tmr_d = tmr_q - TW'(1);
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_addr_d  = cmd_addr_q;
    if (hs) begin
      cmd_valid_d = 1'b0;
      cmd_op_d    = OP_NOP;
      cmd_ba_d    = '0;
      cmd_addr_d  = '0;
    end
    if (state_d != state_q) begin
      case (state_d)
        S_PRE:  begin cmd_valid_d = 1'b1; cmd_op_d = OP_PRE;  cmd_ba_d = g_ba_d; cmd_addr_d = '0; end
        S_ACT:  begin cmd_valid_d = 1'b1; cmd_op_d = OP_ACT;  cmd_ba_d = g_ba_d; cmd_addr_d = g_row_d; end
        S_RW:   begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = g_wr_d ? OP_WR : OP_RD;
          cmd_ba_d    = g_ba_d;
          cmd_addr_d  = ROW_W'(g_col_d);
        end
        S_PREA: begin cmd_valid_d = 1'b1; cmd_op_d = OP_PREA; cmd_ba_d = '0; cmd_addr_d = A10; end
        S_REF:  begin cmd_valid_d = 1'b1; cmd_op_d = OP_REF;  cmd_ba_d = '0; cmd_addr_d = '0; end
        default: ;
      endcase
    end
    rd_ready = (state_q == S_RW) && hs && !g_wr_q;
    wr_ready = (state_q == S_RW) && hs && g_wr_q;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign ref_owed  = ref_owed_q;

endmodule
